// File: rtl/ahb2apb_bridge_v2_pkg.sv
// ahb2apb_pkg: shared types and encodings for the AHB-Lite to APB4 bridge.
//   state_t     : bridge FSM states
//   HTRANS_*    : AHB transfer type encodings
//   HRESP_*     : AHB response encodings
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    SETUP,
    ACCESS,
    DONE,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb2apb_bridge_v2_if.sv
// ahb2apb_bridge_v2_if: AHB-Lite slave port plus APB4 cluster port of the bridge.
//   slave  modport : bridge side (AHB inputs in, AHB response out, APB request out)
//   master modport : environment side (drives AHB requests and APB slave responses)
interface ahb2apb_bridge_v2_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int PSLV_NUM    = 5
);
  // AHB side
  logic                       hsel;
  logic [HADDR_WIDTH-1:0]     haddr;
  logic [1:0]                 htrans;
  logic                       hwrite;
  logic [2:0]                 hsize;
  logic [3:0]                 hprot;
  logic [DATA_WIDTH-1:0]      hwdata;
  logic [DATA_WIDTH/8-1:0]    hwstrb;
  logic                       hready;
  logic                       hreadyout;
  logic                       hresp;
  logic [DATA_WIDTH-1:0]      hrdata;
  // APB side
  logic                       pclken;
  logic [PADDR_WIDTH-1:0]     paddr;
  logic [PSLV_NUM-1:0]        psel;
  logic                       penable;
  logic                       pwrite;
  logic [DATA_WIDTH-1:0]      pwdata;
  logic [DATA_WIDTH/8-1:0]    pstrb;
  logic [2:0]                 pprot;
  logic [PSLV_NUM-1:0]        pready;
  logic [PSLV_NUM*DATA_WIDTH-1:0] prdata;
  logic [PSLV_NUM-1:0]        pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hwstrb, hready,
    output hreadyout, hresp, hrdata,
    input  pclken,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hwstrb, hready,
    input  hreadyout, hresp, hrdata,
    output pclken,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/ahb2apb_bridge_v2_decode.sv
// ahb2apb_decode: combinational address decoder for the APB window.
//   haddr_i : AHB address
//   slot_o  : slave index taken from haddr[PADDR_WIDTH +: SLOT_BITS]
//   sel_o   : one-hot slave select, all zero on a decode error
//   err_o   : base mismatch or slot outside the populated slaves
module ahb2apb_decode
  import ahb2apb_pkg::*;
#(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     PADDR_WIDTH = 16,
  parameter int                     PSLV_NUM    = 5,
  parameter int                     SLOT_BITS   = 4,
  parameter logic [HADDR_WIDTH-1:0] APB_BASE    = 32'h4000_0000
) (
  input  logic [HADDR_WIDTH-1:0] haddr_i,
  output logic [SLOT_BITS-1:0]   slot_o,
  output logic [PSLV_NUM-1:0]    sel_o,
  output logic                   err_o
);
  localparam int TAG_LSB = PADDR_WIDTH + SLOT_BITS;

  logic base_hit;
  logic slot_ok;

  assign slot_o   = haddr_i[PADDR_WIDTH +: SLOT_BITS];
  assign base_hit = (haddr_i[HADDR_WIDTH-1:TAG_LSB] == APB_BASE[HADDR_WIDTH-1:TAG_LSB]);
  assign slot_ok  = (32'(slot_o) < PSLV_NUM);
  assign err_o    = !(base_hit && slot_ok);

  // Each select line only fires for its own slot, so the vector is
  // automatically zero when the slot is out of range.
  for (genvar gi = 0; gi < PSLV_NUM; gi++) begin : g_sel
    assign sel_o[gi] = base_hit && (32'(slot_o) == gi);
  end

endmodule

// File: rtl/ahb2apb_bridge_v2.sv
// ahb2apb_bridge_v2: AHB-Lite slave to APB4 master bridge, single clock domain.
//   hclk   : clock for both bus sides (APB advances on bus.pclken strobes)
//   hreset : synchronous active-high reset
//   bus    : AHB slave port + APB master port (see ahb2apb_bridge_v2_if)
// Every accepted transfer runs PEND -> SETUP -> ACCESS -> DONE; decode errors,
// pslverr and ACCESS timeouts end in a two-cycle ERROR response (ERR1, ERR2).
module ahb2apb_bridge_v2
  import ahb2apb_pkg::*;
#(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     PADDR_WIDTH = 16,
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     PSLV_NUM    = 5,
  parameter int                     SLOT_BITS   = 4,
  parameter logic [HADDR_WIDTH-1:0] APB_BASE    = 32'h4000_0000,
  parameter int                     TIMEOUT     = 256
) (
  input logic                hclk,
  input logic                hreset,
  ahb2apb_bridge_v2_if.slave bus
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t                 state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [PADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                   write_q,   write_d;
  logic [2:0]             prot_q,    prot_d;
  logic [SLOT_BITS-1:0]   slot_q,    slot_d;
  logic [PSLV_NUM-1:0]    sel_q,     sel_d;
  logic [PADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [PSLV_NUM-1:0]    psel_q,    psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q,  pwdata_d;
  logic [STRB_W-1:0]      pstrb_q,   pstrb_d;
  logic [2:0]             pprot_q,   pprot_d;
  logic [DATA_WIDTH-1:0]  hrdata_q,  hrdata_d;

  logic [SLOT_BITS-1:0]   dec_slot;
  logic [PSLV_NUM-1:0]    dec_sel;
  logic                   dec_err;
  logic                   accept;
  logic                   ready_sel;
  logic                   err_sel;
  logic [DATA_WIDTH-1:0]  rd_lane [PSLV_NUM];
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   unused_inputs;

  ahb2apb_decode #(
    .HADDR_WIDTH (HADDR_WIDTH),
    .PADDR_WIDTH (PADDR_WIDTH),
    .PSLV_NUM    (PSLV_NUM),
    .SLOT_BITS   (SLOT_BITS),
    .APB_BASE    (APB_BASE)
  ) u_decode (
    .haddr_i (bus.haddr),
    .slot_o  (dec_slot),
    .sel_o   (dec_sel),
    .err_o   (dec_err)
  );

  // hsize, the low htrans bit and the cacheable/bufferable hprot bits carry
  // nothing the APB side needs.
  assign unused_inputs = ^{bus.hsize, bus.htrans[0], bus.hprot[3:2]};

  assign accept = bus.hsel && bus.htrans[1] && bus.hready;

  // Response of the slave we are talking to; slaves not selected are ignored.
  assign ready_sel = |(bus.pready & sel_q);
  assign err_sel   = |(bus.pslverr & sel_q);

  for (genvar gi = 0; gi < PSLV_NUM; gi++) begin : g_rd_lane
    assign rd_lane[gi] = (slot_q == SLOT_BITS'(gi)) ?
                         bus.prdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < PSLV_NUM; i++) begin
      rd_data = rd_data | rd_lane[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    addr_d    = addr_q;
    write_d   = write_q;
    prot_d    = prot_q;
    slot_d    = slot_q;
    sel_d     = sel_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    hrdata_d  = hrdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          addr_d  = bus.haddr[PADDR_WIDTH-1:0];
          write_d = bus.hwrite;
          // pprot = {instruction, nonsecure, privileged}; AHB-Lite has no
          // security attribute, so every access is issued as secure.
          prot_d  = {!bus.hprot[0], 1'b0, bus.hprot[1]};
          slot_d  = dec_slot;
          sel_d   = dec_sel;
          state_d = dec_err ? ERR1 : PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        // hwdata is valid here because PEND is the stretched data phase.
        if (bus.pclken) begin
          state_d   = SETUP;
          paddr_d   = addr_q;
          psel_d    = sel_q;
          penable_d = 1'b0;
          pwrite_d  = write_q;
          pprot_d   = prot_q;
          pwdata_d  = bus.hwdata;
          pstrb_d   = write_q ? bus.hwstrb : '0;
        end
      end
      SETUP: begin
        if (bus.pclken) begin
          state_d   = ACCESS;
          penable_d = 1'b1;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q;
        if (bus.pclken) begin
          if (ready_sel) begin
            psel_d    = '0;
            penable_d = 1'b0;
            if (err_sel) begin
              state_d = ERR1;
            end else begin
              state_d = DONE;
              if (!write_q) begin
                hrdata_d = rd_data;
              end
            end
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
            // This strobe is the TIMEOUT-th one without pready: abort.
            psel_d    = '0;
            penable_d = 1'b0;
            state_d   = ERR1;
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ERR1:    state_d = ERR2;
      // A transfer presented during ERR2 must be cancelled by the master.
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      prot_q    <= '0;
      slot_q    <= '0;
      sel_q     <= '0;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      prot_q    <= prot_d;
      slot_q    <= slot_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign bus.hreadyout = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
  assign bus.hresp     = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = hrdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;

endmodule

// File: tb/tb_ahb2apb_bridge_v2.sv
// tb_ahb2apb_bridge_v2: randomized + directed bench for ahb2apb_bridge_v2.
// Expected timing is derived from the pclken strobe timeline of each transfer.
module tb_ahb2apb_bridge_v2;
  import ahb2apb_pkg::*;

  localparam int NSLV = 5;
  localparam int TOUT = 4;

  logic hclk;
  logic hreset;

  ahb2apb_bridge_v2_if #(
    .HADDR_WIDTH (32), .PADDR_WIDTH (16), .DATA_WIDTH (32), .PSLV_NUM (NSLV)
  ) bus ();

  ahb2apb_bridge_v2 #(
    .HADDR_WIDTH (32), .PADDR_WIDTH (16), .DATA_WIDTH (32), .PSLV_NUM (NSLV),
    .SLOT_BITS (4), .APB_BASE (32'h4000_0000), .TIMEOUT (TOUT)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int clk_div = 1;
  int rdy_dly = 0;
  int acc_cnt = 0;
  int xfer_no = 0;
  logic slv_err = 1'b0;
  logic [31:0] slv_data [NSLV];
  logic [31:0] model_rdata = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: the APB slave model counts ACCESS strobes it saw and raises
  // pready once rdy_dly of them have passed.
  task automatic step();
    logic acc;
    acc = (bus.psel != '0) && bus.penable && bus.pclken;
    @(posedge hclk);
    #1;
    cyc++;
    if (acc) acc_cnt++;
    bus.pclken  = ((cyc % clk_div) == 0);
    bus.pready  = {NSLV{acc_cnt >= rdy_dly}};
    bus.pslverr = {NSLV{slv_err && (acc_cnt >= rdy_dly)}};
    bus.hready  = bus.hreadyout;
  endtask

  function automatic int next_strobe(input int from, input int n);
    int c;
    c = from;
    while ((c % n) != 0) c++;
    return c;
  endfunction

  task automatic load_slaves(input int slot, input logic [31:0] rdata);
    for (int i = 0; i < NSLV; i++) begin
      slv_data[i] = $urandom;
      if (i == slot) slv_data[i] = rdata;
      bus.prdata[i*32 +: 32] = slv_data[i];
    end
  endtask

  // Presents one transfer in the current (ready) cycle and follows it to its
  // response. Leaves the bench in DONE when b2b is set and the transfer is
  // OKAY, otherwise in IDLE.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [3:0] prot, input logic [31:0] rdata,
                         input int n, input int dly, input logic serr, input logic b2b,
                         input logic poke);
    int a, s1, s2, t, r, k, slot, exp_wait, waits;
    logic dec_bad, exp_err, psel_seen, pen_seen, last_resp;
    logic [4:0] exp_sel;
    s1 = 0; s2 = 0;
    clk_div = n; rdy_dly = dly; slv_err = serr; acc_cnt = 0;
    slot = int'(addr[19:16]);
    dec_bad = (addr[31:20] != 12'h400) || (slot >= NSLV);
    exp_sel = dec_bad ? 5'b0 : 5'(1 << slot);
    load_slaves(dec_bad ? -1 : slot, rdata);
    a = cyc;
    if (dec_bad) begin
      exp_err = 1'b1;
      r = a + 1;
    end else begin
      s1 = next_strobe(a + 1, n);
      s2 = next_strobe(s1 + 1, n);
      k = (dly + 1 <= TOUT) ? dly + 1 : TOUT;
      exp_err = serr || (dly + 1 > TOUT);
      t = s2;
      for (int j = 0; j < k; j++) t = next_strobe(t + 1, n);
      r = t + 1;
    end
    exp_wait = exp_err ? (r - a) : (r - a - 1);

    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.haddr = addr;
    bus.hwrite = wr; bus.hprot = prot; bus.hsize = 3'd2;
    step();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.haddr = $urandom;
    bus.hwdata = wdata; bus.hwstrb = strb;

    waits = 0; psel_seen = 1'b0; pen_seen = 1'b0; last_resp = 1'b0;
    while (bus.hreadyout == 1'b0 && waits < 300) begin
      check_eq("psel_legal", 64'((bus.psel == '0) || (bus.psel == exp_sel)), 64'(1));
      if (bus.psel != '0 && !psel_seen) begin
        psel_seen = 1'b1;
        check_eq("setup_cycle", 64'(cyc), 64'(s1 + 1));
        check_eq("paddr",   64'(bus.paddr),   64'(addr[15:0]));
        check_eq("penable_setup", 64'(bus.penable), 64'(0));
        check_eq("pwrite",  64'(bus.pwrite),  64'(wr));
        check_eq("pwdata",  64'(bus.pwdata),  64'(wdata));
        check_eq("pstrb",   64'(bus.pstrb),   64'(wr ? strb : 4'b0));
        check_eq("pprot",   64'(bus.pprot),   64'({!prot[0], 1'b0, prot[1]}));
      end
      if (bus.penable && !pen_seen) begin
        pen_seen = 1'b1;
        check_eq("access_cycle", 64'(cyc), 64'(s2 + 1));
      end
      last_resp = bus.hresp;
      step();
      waits++;
    end
    if (!exp_err && !wr) model_rdata = slv_data[slot];
    check_eq("wait_states", 64'(waits), 64'(exp_wait));
    check_eq("hresp_last",  64'(bus.hresp), 64'(exp_err));
    check_eq("hresp_wait",  64'(last_resp), 64'(exp_err));
    check_eq("psel_seen",   64'(psel_seen), 64'(!dec_bad));
    check_eq("psel_clear",  64'(bus.psel), 64'(0));
    check_eq("penable_clear", 64'(bus.penable), 64'(0));
    check_eq("hrdata",      64'(bus.hrdata), 64'(model_rdata));
    xfer_no++;
    $display("xfer %0d addr=%08h wr=%0d n=%0d dly=%0d serr=%0d waits=%0d hresp=%0d hrdata=%08h",
             xfer_no, addr, wr, n, dly, serr, waits, bus.hresp, bus.hrdata);

    if (exp_err) begin
      if (poke) begin
        bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h4000_0000; bus.hwrite = 1'b0;
        step();
        bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
        check_eq("err2_ignore_ready", 64'(bus.hreadyout), 64'(1));
        check_eq("err2_ignore_psel",  64'(bus.psel), 64'(0));
      end else begin
        step();
      end
    end else if (!b2b) begin
      step();
    end
  endtask

  task automatic idle_xfer(input logic [1:0] tr);
    bus.hsel = 1'b1; bus.htrans = tr; bus.haddr = 32'h4001_0000;
    step();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    check_eq("idle_ready", 64'(bus.hreadyout), 64'(1));
    check_eq("idle_resp",  64'(bus.hresp), 64'(0));
  endtask

  initial begin
    logic [31:0] addr;
    int guard;
    hreset = 1'b1;
    bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
    bus.hsize = 3'd2; bus.hprot = '0; bus.hwdata = '0; bus.hwstrb = '0; bus.hready = 1'b1;
    bus.pclken = 1'b1; bus.pready = '0; bus.prdata = '0; bus.pslverr = '0;
    repeat (3) step();
    check_eq("rst_hreadyout", 64'(bus.hreadyout), 64'(1));
    check_eq("rst_hresp",   64'(bus.hresp),   64'(0));
    check_eq("rst_hrdata",  64'(bus.hrdata),  64'(0));
    check_eq("rst_psel",    64'(bus.psel),    64'(0));
    check_eq("rst_penable", 64'(bus.penable), 64'(0));
    check_eq("rst_paddr",   64'(bus.paddr),   64'(0));
    check_eq("rst_pwrite",  64'(bus.pwrite),  64'(0));
    check_eq("rst_pwdata",  64'(bus.pwdata),  64'(0));
    check_eq("rst_pstrb",   64'(bus.pstrb),   64'(0));
    check_eq("rst_pprot",   64'(bus.pprot),   64'(0));
    hreset = 1'b0;
    step();

    // Directed cases
    do_xfer(32'h4001_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'h3, 32'h0, 1, 0, 1'b0, 1'b0, 1'b0);
    do_xfer(32'h4003_0010, 1'b0, 32'h0, 4'h0, 4'h1, 32'h1234_5678, 3, 2, 1'b0, 1'b0, 1'b0);
    do_xfer(32'h4005_0000, 1'b0, 32'h0, 4'h0, 4'h1, 32'h0, 1, 0, 1'b0, 1'b0, 1'b1);
    do_xfer(32'h4002_0020, 1'b1, 32'hCAFE_0001, 4'h3, 4'h2, 32'h0, 1, 0, 1'b1, 1'b0, 1'b0);
    do_xfer(32'h4000_0040, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1, 100, 1'b0, 1'b0, 1'b0);
    do_xfer(32'h4000_0044, 1'b0, 32'h0, 4'h0, 4'h0, 32'hA5A5_0F0F, 2, 1, 1'b0, 1'b0, 1'b0);
    idle_xfer(HTRANS_IDLE);
    idle_xfer(HTRANS_BUSY);

    // Reset while in ACCESS
    clk_div = 1; rdy_dly = 100; slv_err = 1'b0; acc_cnt = 0;
    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h4000_0008; bus.hwrite = 1'b1;
    step();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    guard = 0;
    while (!bus.penable && guard < 20) begin step(); guard++; end
    check_eq("reach_access", 64'(bus.penable), 64'(1));
    hreset = 1'b1;
    step();
    model_rdata = '0;
    check_eq("mid_rst_psel",    64'(bus.psel),      64'(0));
    check_eq("mid_rst_penable", 64'(bus.penable),   64'(0));
    check_eq("mid_rst_ready",   64'(bus.hreadyout), 64'(1));
    check_eq("mid_rst_hresp",   64'(bus.hresp),     64'(0));
    check_eq("mid_rst_hrdata",  64'(bus.hrdata),    64'(0));
    hreset = 1'b0;
    step();

    // Back-to-back: second transfer accepted in DONE
    do_xfer(32'h4004_0100, 1'b0, 32'h0, 4'h0, 4'h1, 32'h0BAD_F00D, 1, 0, 1'b0, 1'b1, 1'b0);
    do_xfer(32'h4001_0200, 1'b0, 32'h0, 4'h0, 4'h1, 32'h7777_1111, 1, 0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_xfer($urandom_range(0, 1) == 0 ? HTRANS_IDLE : HTRANS_BUSY);
      end else begin
        case ($urandom_range(0, 9))
          0: addr = {12'h3FF, 4'($urandom_range(0, 4)), 16'($urandom) & 16'hFFFC};
          1: addr = {12'h400, 4'($urandom_range(5, 15)), 16'($urandom) & 16'hFFFC};
          default: addr = {12'h400, 4'($urandom_range(0, 4)), 16'($urandom) & 16'hFFFC};
        endcase
        do_xfer(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 4'($urandom), $urandom,
                $urandom_range(1, 3), $urandom_range(0, 5), ($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge_v2.md
Name: ahb2apb_bridge_v2

Overview:
- Next-generation AHB-Lite to APB4 bridge with a registered APB side.
- Each accepted AHB transfer runs a proper SETUP/ACCESS sequence on one of PSLV_NUM slaves. APB phases advance only on pclken strobes, so APB runs at hclk/N in the same clock domain.
- Adds behaviour the current bridge lacks:
  - address decode against a base address;
  - hwdata captured in the AHB data phase;
  - pslverr, decode error and timeout reported as a two-cycle AHB ERROR response;
  - registered hrdata.
- Sits between the AHB interconnect slave port and the APB peripheral cluster (UART/SPI/I2C/memory/LED).

Parameters:
- HADDR_WIDTH, 32, AHB address width.
- PADDR_WIDTH, 16, APB address width; the per-slave window is 2^PADDR_WIDTH bytes.
- DATA_WIDTH, 32, data width; legal values 8/16/32.
- PSLV_NUM, 5, number of APB slaves, 1..16.
- SLOT_BITS, 4, haddr bits used as slave index, at haddr[PADDR_WIDTH +: SLOT_BITS].
- APB_BASE, 32'h4000_0000, base address; haddr[HADDR_WIDTH-1:PADDR_WIDTH+SLOT_BITS] must equal the matching APB_BASE bits.
- TIMEOUT, 256, pclken cycles allowed in ACCESS before abort; 0 disables the timeout.

Ports:
- hclk input 1: single clock for the AHB and APB sides.
- hreset input 1: synchronous, active-high reset.
- hsel input 1: AHB slave select.
- haddr input HADDR_WIDTH: AHB address.
- htrans input 2: AHB transfer type.
- hwrite input 1: AHB write.
- hsize input 3: AHB size; not checked, forwarded nowhere.
- hprot input 4: AHB protection; mapped to pprot.
- hwdata input DATA_WIDTH: write data, valid in the data phase.
- hwstrb input DATA_WIDTH/8: write strobes, valid in the data phase.
- hready input 1: bus-level hready.
- hreadyout output 1: slave ready.
- hresp output 1: 0 = OKAY, 1 = ERROR.
- hrdata output DATA_WIDTH: registered read data.
- pclken input 1: APB clock-enable strobe.
- paddr output PADDR_WIDTH: APB address.
- psel output PSLV_NUM: one-hot APB select.
- penable output 1: APB enable.
- pwrite output 1: APB write.
- pwdata output DATA_WIDTH: APB write data.
- pstrb output DATA_WIDTH/8: APB write strobes.
- pprot output 3: APB protection.
- pready input PSLV_NUM: per-slave ready.
- prdata input PSLV_NUM*DATA_WIDTH: per-slave read data, flattened with slave i at [i*DATA_WIDTH +: DATA_WIDTH].
- pslverr input PSLV_NUM: per-slave error.

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, pprot=0, state=IDLE, timeout counter=0.
- Reset mid-transfer aborts immediately: the next edge gives psel=0 and penable=0, with no error reported.
- Accept condition: hsel & htrans[1] & hready, in IDLE or DONE.
  - On accept, latch address, hwrite, prot and slot; the decoded slave index feeds the one-hot psel in SETUP.
  - IDLE/BUSY transfers get a zero-wait OKAY.
- Decode error: base mismatch or slot >= PSLV_NUM. Go to ERR1; no APB access is issued.
- States and transitions:
  - IDLE: hreadyout=1. Accept -> PEND; accept with decode error -> ERR1.
  - PEND: hreadyout=0. When pclken=1 -> SETUP. On that edge capture hwdata/hwstrb into pwdata/pstrb (pstrb=0 for reads), drive paddr and psel one-hot, penable=0.
  - SETUP: when pclken=1 -> ACCESS with penable=1.
  - ACCESS:
    - pclken & pready[slot] & !pslverr[slot] -> DONE. On a read, capture prdata slot into hrdata.
    - pclken & pready[slot] & pslverr[slot] -> ERR1.
    - Counter reaches TIMEOUT (counts pclken strobes in ACCESS) -> ERR1.
    - Leaving ACCESS clears psel and penable.
  - DONE: hreadyout=1, hresp=0 for one cycle. Accept -> PEND/ERR1; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1. Then -> IDLE. A transfer presented in ERR2 is ignored, since the master must cancel it.
- Latency with pclken tied 1 and pready=1: accept at cycle 0, PEND at 1, SETUP at 2, ACCESS at 3, DONE at 4. That is 3 wait states.
- pclken toggling every N cycles stretches PEND, SETUP and ACCESS to N-cycle alignment.
- APB outputs are stable between pclken edges. psel is always one-hot or zero.
- hrdata holds its last captured value outside DONE; writes do not change it.

Decomposition:
- Package ahb2apb_pkg:
  - state_t enum: IDLE, PEND, SETUP, ACCESS, DONE, ERR1, ERR2;
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR.
- Sub-module ahb2apb_decode, combinational: takes haddr; outputs slot index, one-hot select, decode error.
- FSM, timeout counter and output registers stay in the top module.

Test Plan:
- Write at haddr 0x4001_0004, hwdata 0xDEAD_BEEF, pclken=1, pready=1 -> psel=5'b00010, paddr=0x0004, pwdata=0xDEAD_BEEF, penable rises one cycle after psel, hreadyout low for exactly 3 cycles, hresp=0.
- Read at 0x4003_0010 with slave3 prdata=0x1234_5678, pclken every 3rd cycle, pready delayed 2 strobes -> hrdata=0x1234_5678 in DONE, SETUP/ACCESS edges aligned to pclken.
- Read at 0x4005_0000 (slot 5 >= PSLV_NUM) -> psel never asserts; ERR1 then ERR2 (hreadyout 0 then 1, hresp=1 both cycles).
- Write to slave2 with pslverr=1 at pready -> two-cycle ERROR response; psel cleared after ACCESS.
- TIMEOUT=4, slave0 pready held 0 -> abort after 4 pclken strobes in ACCESS, ERROR response, bridge returns to IDLE and a following access succeeds.
- hreset asserted during ACCESS -> next edge gives psel=0, penable=0, hreadyout=1, hrdata=0; back-to-back accept in DONE proceeds without an IDLE cycle.
